bf_run_ctrl: RTL and testbench

Sequencer wrapping the brainfuck core. Streams a program from a byte source into program RAM, dropping non-command bytes and checking bracket balance. Then zero-fills data RAM, resets and enables the core, and watches it until it halts or exceeds a cycle budget. While loading or clearing it owns both RAM write ports; an external mux selects on mem_own.

---
 rtl/bf_run_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_bf_run_ctrl.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_run_ctrl.sv
// bf_run_ctrl: load / clear / run sequencer around the brainfuck core.
// Streams a program into program RAM, filtering non-commands and checking
// bracket balance, zero-fills data RAM, then resets and runs the core until
// it fetches the terminator or exhausts its cycle budget.
module bf_run_ctrl #(
    parameter int unsigned PROG_ADDR_WIDTH = 8,
    parameter int unsigned DATA_ADDR_WIDTH = 8,
    parameter int unsigned STACK_DEPTH     = 32,
    parameter int unsigned MAX_CYCLES      = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [7:0]                 rx_data_i,
    input  logic                       rx_valid_i,
    output logic                       rx_ready_o,
    output logic [PROG_ADDR_WIDTH-1:0] pmem_waddr_o,
    output logic [7:0]                 pmem_wdata_o,
    output logic                       pmem_wen_o,
    output logic [DATA_ADDR_WIDTH-1:0] dmem_waddr_o,
    output logic                       dmem_wen_o,
    output logic                       mem_own_o,
    output logic                       cpu_reset_o,
    output logic                       cpu_en_o,
    input  logic [PROG_ADDR_WIDTH-1:0] cpu_prog_addr_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [2:0]                 err_code_o,
    output logic [31:0]                cycles_o
);

    localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
    localparam logic [DepthW-1:0]          DepthMax   = DepthW'(STACK_DEPTH);
    localparam logic [PROG_ADDR_WIDTH-1:0] ProgLast   = '1;
    localparam logic [DATA_ADDR_WIDTH-1:0] DataLast   = '1;
    localparam logic [31:0]                CycleLimit = 32'(MAX_CYCLES);

    localparam logic [2:0] ErrNone    = 3'd0;
    localparam logic [2:0] ErrClose   = 3'd1;
    localparam logic [2:0] ErrNest    = 3'd2;
    localparam logic [2:0] ErrOpen    = 3'd3;
    localparam logic [2:0] ErrAbort   = 3'd4;
    localparam logic [2:0] ErrTimeout = 3'd5;

    localparam logic [7:0] ChOpen  = 8'h5B;
    localparam logic [7:0] ChClose = 8'h5D;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StClear,
        StRunRst,
        StRun,
        StDone,
        StErr
    } state_e;

    state_e                     state_q, state_d;
    logic [PROG_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DepthW-1:0]          depth_q, depth_d;
    logic [DATA_ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic [PROG_ADDR_WIDTH-1:0] term_addr_q, term_addr_d;
    logic [2:0]                 err_code_q, err_code_d;
    logic [31:0]                cycles_q, cycles_d;
    logic                       rst_cnt_q, rst_cnt_d;
    logic                       is_cmd;
    logic                       accept;

    // Classify the incoming byte as one of the eight commands.
    always_comb begin
        case (rx_data_i)
            8'h3C, 8'h3E, 8'h2B, 8'h2D, 8'h2E, 8'h2C, 8'h5B, 8'h5D: is_cmd = 1'b1;
            default:                                                 is_cmd = 1'b0;
        endcase
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            depth_q     <= '0;
            clr_ptr_q   <= '0;
            term_addr_q <= '0;
            err_code_q  <= ErrNone;
            cycles_q    <= '0;
            rst_cnt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            depth_q     <= depth_d;
            clr_ptr_q   <= clr_ptr_d;
            term_addr_q <= term_addr_d;
            err_code_q  <= err_code_d;
            cycles_q    <= cycles_d;
            rst_cnt_q   <= rst_cnt_d;
        end
    end

    // Next-state logic; the program write strobe is combinational with the handshake.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        depth_d     = depth_q;
        clr_ptr_d   = clr_ptr_q;
        term_addr_d = term_addr_q;
        err_code_d  = err_code_q;
        cycles_d    = cycles_q;
        rst_cnt_d   = rst_cnt_q;
        pmem_wen_o  = 1'b0;
        accept      = (state_q == StLoad) && rx_valid_i;

        case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    state_d    = StLoad;
                    wr_ptr_d   = '0;
                    depth_d    = '0;
                    err_code_d = ErrNone;
                    cycles_d   = '0;
                end
            end
            StLoad: begin
                if (abort_i) begin
                    state_d    = StErr;
                    err_code_d = ErrAbort;
                end else if (accept) begin
                    if (rx_data_i == 8'h00) begin
                        // Terminator fits even in the last slot.
                        pmem_wen_o  = 1'b1;
                        term_addr_d = wr_ptr_q;
                        if (depth_q != '0) begin
                            state_d    = StErr;
                            err_code_d = ErrOpen;
                        end else begin
                            state_d   = StClear;
                            clr_ptr_d = '0;
                        end
                    end else if (is_cmd) begin
                        // Errored commands are consumed but never written.
                        if (wr_ptr_q == ProgLast) begin
                            state_d    = StErr;
                            err_code_d = ErrOpen;
                        end else if (rx_data_i == ChClose && depth_q == '0) begin
                            state_d    = StErr;
                            err_code_d = ErrClose;
                        end else if (rx_data_i == ChOpen && depth_q == DepthMax) begin
                            state_d    = StErr;
                            err_code_d = ErrNest;
                        end else begin
                            pmem_wen_o = 1'b1;
                            wr_ptr_d   = wr_ptr_q + 1'b1;
                            if (rx_data_i == ChOpen) begin
                                depth_d = depth_q + 1'b1;
                            end else if (rx_data_i == ChClose) begin
                                depth_d = depth_q - 1'b1;
                            end
                        end
                    end
                end
            end
            StClear: begin
                if (abort_i) begin
                    state_d    = StErr;
                    err_code_d = ErrAbort;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                    if (clr_ptr_q == DataLast) begin
                        state_d   = StRunRst;
                        rst_cnt_d = 1'b0;
                    end
                end
            end
            StRunRst: begin
                if (abort_i) begin
                    state_d    = StErr;
                    err_code_d = ErrAbort;
                end else begin
                    rst_cnt_d = 1'b1;
                    if (rst_cnt_q) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (abort_i) begin
                    state_d    = StErr;
                    err_code_d = ErrAbort;
                end else begin
                    cycles_d = cycles_q + 32'd1;
                    // Halt detection takes priority over the budget check.
                    if (cpu_prog_addr_i == term_addr_q) begin
                        state_d = StDone;
                    end else if (cycles_d >= CycleLimit) begin
                        state_d    = StErr;
                        err_code_d = ErrTimeout;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        rx_ready_o   = (state_q == StLoad);
        pmem_waddr_o = wr_ptr_q;
        pmem_wdata_o = rx_data_i;
        dmem_waddr_o = clr_ptr_q;
        dmem_wen_o   = (state_q == StClear);
        mem_own_o    = (state_q == StLoad) || (state_q == StClear);
        cpu_reset_o  = (state_q != StRun);
        cpu_en_o     = (state_q == StRunRst) || (state_q == StRun);
        // The two-cycle core reset counts as part of the run phase.
        busy_o       = (state_q == StLoad) || (state_q == StClear) ||
                       (state_q == StRunRst) || (state_q == StRun);
        done_o       = (state_q == StDone);
        err_code_o   = err_code_q;
        cycles_o     = cycles_q;
    end

endmodule

// File: tb/tb_bf_run_ctrl.sv
// Bench for bf_run_ctrl: byte-classification vectors, hand-written corner
// sequences and random program streams checked against a stream-level model.
module tb_bf_run_ctrl;

    localparam int unsigned PAW = 8;
    localparam int unsigned DAW = 8;
    localparam int unsigned SD  = 32;
    localparam int unsigned MC  = 50;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start_i = 1'b0;
    logic           abort_i = 1'b0;
    logic [7:0]     rx_data_i = 8'h00;
    logic           rx_valid_i = 1'b0;
    logic           rx_ready_o;
    logic [PAW-1:0] pmem_waddr_o;
    logic [7:0]     pmem_wdata_o;
    logic           pmem_wen_o;
    logic [DAW-1:0] dmem_waddr_o;
    logic           dmem_wen_o;
    logic           mem_own_o;
    logic           cpu_reset_o;
    logic           cpu_en_o;
    logic [PAW-1:0] cpu_prog_addr_i = '0;
    logic           busy_o;
    logic           done_o;
    logic [2:0]     err_code_o;
    logic [31:0]    cycles_o;

    always #5 clk = ~clk;

    bf_run_ctrl #(
        .PROG_ADDR_WIDTH(PAW),
        .DATA_ADDR_WIDTH(DAW),
        .STACK_DEPTH    (SD),
        .MAX_CYCLES     (MC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_ready_o     (rx_ready_o),
        .pmem_waddr_o   (pmem_waddr_o),
        .pmem_wdata_o   (pmem_wdata_o),
        .pmem_wen_o     (pmem_wen_o),
        .dmem_waddr_o   (dmem_waddr_o),
        .dmem_wen_o     (dmem_wen_o),
        .mem_own_o      (mem_own_o),
        .cpu_reset_o    (cpu_reset_o),
        .cpu_en_o       (cpu_en_o),
        .cpu_prog_addr_i(cpu_prog_addr_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_code_o     (err_code_o),
        .cycles_o       (cycles_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        got_wr[$];
    wr_t        exp_wr[$];
    logic [7:0] stream[$];
    int         exp_err;
    int         exp_used;
    int         exp_term;
    bit         exp_clear;
    int         clr_idx = 0;

    // Capture program writes and check that the clear walks addresses in order.
    always @(negedge clk) begin
        #2;
        if (pmem_wen_o) got_wr.push_back({pmem_waddr_o, pmem_wdata_o});
        if (dmem_wen_o) begin
            check("clear_addr", 32'(dmem_waddr_o), 32'(clr_idx));
            clr_idx++;
        end else begin
            clr_idx = 0;
        end
    end

    function automatic bit is_cmd_ref(input logic [7:0] b);
        string cmds = "<>+-.,[]";
        for (int i = 0; i < cmds.len(); i++) begin
            if (b == cmds[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Stream-level reference: which bytes land where, and how loading ends.
    function automatic void run_model();
        int         ptr;
        int         depth;
        logic [7:0] b;
        ptr = 0;
        depth = 0;
        exp_wr.delete();
        exp_err = 0;
        exp_used = 0;
        exp_term = 0;
        exp_clear = 1'b0;
        foreach (stream[i]) begin
            b = stream[i];
            exp_used++;
            if (b == 8'h00) begin
                exp_wr.push_back({8'(ptr), 8'h00});
                exp_term = ptr;
                if (depth > 0) exp_err = 3;
                else exp_clear = 1'b1;
                return;
            end
            if (is_cmd_ref(b)) begin
                if (ptr == (1 << PAW) - 1) begin
                    exp_err = 3;
                    return;
                end
                if (b == 8'h5D) begin
                    if (depth == 0) begin
                        exp_err = 1;
                        return;
                    end
                    depth--;
                end
                if (b == 8'h5B) begin
                    depth++;
                    if (depth > SD) begin
                        exp_err = 2;
                        return;
                    end
                end
                exp_wr.push_back({8'(ptr), b});
                ptr++;
            end
        end
    endfunction

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            rx_valid_i = 1'b0;
            rx_data_i  = 8'($urandom);
            @(negedge clk);
        end
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        n = 0;
        while (!rx_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_wait", 32'(rx_ready_o), 32'd1);
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    // Follow CLEAR, RUN_RST and RUN; the fake core hits the terminator on run cycle k.
    task automatic run_phase(input int k, input logic [7:0] term);
        int         n;
        logic [7:0] miss;
        int         exp_cyc;
        miss = term + 8'd1;
        cpu_prog_addr_i = miss;
        check("clear_mem_own", 32'(mem_own_o), 32'd1);
        n = 0;
        while (dmem_wen_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("clear_cycles", 32'(n), 32'd256);
        check("runrst_mem_own", 32'(mem_own_o), 32'd0);
        n = 0;
        while (cpu_en_o && cpu_reset_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("runrst_cycles", 32'(n), 32'd2);
        check("run_entry", {30'd0, cpu_en_o, cpu_reset_o}, 32'd2);
        n = 0;
        while (cpu_en_o && n < 200) begin
            n++;
            cpu_prog_addr_i = (n == k) ? term : miss;
            @(negedge clk);
        end
        exp_cyc = (k >= 1 && k <= int'(MC)) ? k : int'(MC);
        check("run_done", 32'(done_o), (k >= 1 && k <= int'(MC)) ? 32'd1 : 32'd0);
        check("run_err", 32'(err_code_o), (k >= 1 && k <= int'(MC)) ? 32'd0 : 32'd5);
        check("run_cycles", cycles_o, 32'(exp_cyc));
        check("run_end_idle", {30'd0, cpu_en_o, busy_o}, 32'd0);
        repeat (3) @(negedge clk);
        check("cycles_frozen", cycles_o, 32'(exp_cyc));
    endtask

    task automatic run_stream(input int k);
        int m;
        run_model();
        got_wr.delete();
        pulse_start();
        check("start_err_clr", 32'(err_code_o), 32'd0);
        check("start_load", 32'(rx_ready_o), 32'd1);
        for (int i = 0; i < exp_used; i++) send_byte(stream[i]);
        check("pmem_nwrites", 32'(got_wr.size()), 32'(exp_wr.size()));
        m = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
        for (int i = 0; i < m; i++) check("pmem_write", 32'(got_wr[i]), 32'(exp_wr[i]));
        if (exp_clear) begin
            run_phase(k, 8'(exp_term));
        end else begin
            check("load_err", 32'(err_code_o), 32'(exp_err));
            check("load_err_idle", {29'd0, rx_ready_o, busy_o, mem_own_o}, 32'd0);
        end
    endtask

    task automatic gen_stream();
        int         len;
        int         depth;
        int         r;
        logic [7:0] ops[6];
        logic [7:0] fill[5];
        ops  = '{8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C};
        fill = '{8'h61, 8'h20, 8'h0A, 8'hFF, 8'h30};
        len = $urandom_range(1, 30);
        depth = 0;
        stream.delete();
        for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                stream.push_back(fill[$urandom_range(0, 4)]);
            end else if (r < 27) begin
                stream.push_back(8'h5B);
                depth++;
            end else if (r < 40) begin
                if (depth > 0 || r < 29) begin
                    stream.push_back(8'h5D);
                    depth--;
                end
            end else begin
                stream.push_back(ops[$urandom_range(0, 5)]);
            end
        end
        if ($urandom_range(0, 3) != 0) begin
            while (depth > 0) begin
                stream.push_back(8'h5D);
                depth--;
            end
        end
        stream.push_back(8'h00);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       wen;
        logic [2:0] err;
        logic       ready_next;
        logic       clr_next;
    } vec_t;

    vec_t vt[12];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{8'h2B, 1'b1, 3'd0, 1'b1, 1'b0};
        vt[1]  = '{8'h2D, 1'b1, 3'd0, 1'b1, 1'b0};
        vt[2]  = '{8'h3C, 1'b1, 3'd0, 1'b1, 1'b0};
        vt[3]  = '{8'h3E, 1'b1, 3'd0, 1'b1, 1'b0};
        vt[4]  = '{8'h2E, 1'b1, 3'd0, 1'b1, 1'b0};
        vt[5]  = '{8'h2C, 1'b1, 3'd0, 1'b1, 1'b0};
        vt[6]  = '{8'h5B, 1'b1, 3'd0, 1'b1, 1'b0};
        vt[7]  = '{8'h5D, 1'b0, 3'd1, 1'b0, 1'b0};
        vt[8]  = '{8'h00, 1'b1, 3'd0, 1'b0, 1'b1};
        vt[9]  = '{8'h61, 1'b0, 3'd0, 1'b1, 1'b0};
        vt[10] = '{8'hFF, 1'b0, 3'd0, 1'b1, 1'b0};
        vt[11] = '{8'h20, 1'b0, 3'd0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_strobes", {29'd0, pmem_wen_o, dmem_wen_o, rx_ready_o}, 32'd0);
        check("rst_mem_own", 32'(mem_own_o), 32'd0);
        check("rst_cpu", {30'd0, cpu_reset_o, cpu_en_o}, 32'd2);
        check("rst_status", {30'd0, done_o, busy_o}, 32'd0);
        check("rst_err", 32'(err_code_o), 32'd0);
        check("rst_cycles", cycles_o, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // rx_valid in IDLE is not consumed
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h2B;
        #1;
        check("idle_no_ready", {30'd0, rx_ready_o, pmem_wen_o}, 32'd0);
        @(negedge clk);
        rx_valid_i = 1'b0;

        // Single-byte classification from a fresh LOAD
        foreach (vt[i]) begin
            pulse_start();
            rx_data_i  = vt[i].b;
            rx_valid_i = 1'b1;
            #1;
            check("vec_wen", 32'(pmem_wen_o), 32'(vt[i].wen));
            if (vt[i].wen) check("vec_wdata", {16'd0, pmem_waddr_o, pmem_wdata_o}, {24'd0, vt[i].b});
            @(negedge clk);
            rx_valid_i = 1'b0;
            #1;
            check("vec_ready", 32'(rx_ready_o), 32'(vt[i].ready_next));
            check("vec_err", 32'(err_code_o), 32'(vt[i].err));
            check("vec_clear", 32'(dmem_wen_o), 32'(vt[i].clr_next));
            @(negedge clk);
            abort_i = 1'b1;
            @(negedge clk);
            abort_i = 1'b0;
            check("vec_abort", 32'(err_code_o), (vt[i].err != 0) ? 32'(vt[i].err) : 32'd4);
        end

        // "++[->+<]." then terminator; core halts on run cycle 10
        stream = '{8'h2B, 8'h2B, 8'h5B, 8'h2D, 8'h3E, 8'h2B, 8'h3C, 8'h5D, 8'h2E, 8'h00};
        run_stream(10);
        check("ex1_nwrites", 32'(got_wr.size()), 32'd9 + 32'd1);
        rx_valid_i = 1'b1;
        #1;
        check("done_no_ready", {30'd0, rx_ready_o, pmem_wen_o}, 32'd0);
        @(negedge clk);
        rx_valid_i = 1'b0;
        check("done_held", 32'(done_o), 32'd1);

        // Fillers are consumed but not written
        stream = '{8'h2B, 8'h61, 8'h20, 8'h62, 8'h0A, 8'h2D, 8'h00};
        run_stream(5);
        check("ex2_nwrites", 32'(got_wr.size()), 32'd3);

        stream = '{8'h5D};
        run_stream(0);
        stream = '{8'h5B, 8'h5B, 8'h00};
        run_stream(0);
        stream.delete();
        for (int i = 0; i < 33; i++) stream.push_back(8'h5B);
        run_stream(0);
        check("nest_err", 32'(err_code_o), 32'd2);

        // Timeout, and halt exactly on the last budgeted cycle
        stream = '{8'h2B, 8'h5B, 8'h5D, 8'h00};
        run_stream(0);
        check("timeout_err", 32'(err_code_o), 32'd5);
        stream = '{8'h2B, 8'h00};
        run_stream(int'(MC));

        // Program RAM capacity: 255 commands leave room only for the terminator
        stream.delete();
        for (int i = 0; i < 256; i++) stream.push_back(8'h2B);
        run_stream(0);
        check("overflow_err", 32'(err_code_o), 32'd3);
        stream[255] = 8'h00;
        run_stream(3);

        // Abort mid-CLEAR, then restart
        stream = '{8'h2B, 8'h00};
        pulse_start();
        send_byte(8'h2B);
        send_byte(8'h00);
        begin
            int n;
            n = 0;
            while (dmem_waddr_o != 8'd10 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("clr_reach10", {23'd0, dmem_wen_o, dmem_waddr_o}, 32'h10A);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        #1;
        check("abort_dmem", {30'd0, dmem_wen_o, mem_own_o}, 32'd0);
        check("abort_err", 32'(err_code_o), 32'd4);
        @(negedge clk);
        pulse_start();
        check("restart_err", 32'(err_code_o), 32'd0);
        check("restart_load", 32'(rx_ready_o), 32'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;

        // start ignored in RUN, then reset mid-RUN
        pulse_start();
        send_byte(8'h2B);
        send_byte(8'h00);
        cpu_prog_addr_i = 8'hFF;
        begin
            int n;
            n = 0;
            while (!(cpu_en_o && !cpu_reset_o) && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        check("run_reached", 32'(cpu_en_o && !cpu_reset_o), 32'd1);
        repeat (5) @(negedge clk);
        pulse_start();
        #1;
        check("start_in_run", {30'd0, cpu_en_o, busy_o}, 32'd3);
        check("start_in_run_cyc", cycles_o, 32'd6);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("midrun_rst_cpu", {30'd0, cpu_reset_o, cpu_en_o}, 32'd2);
        check("midrun_rst_busy", {30'd0, busy_o, done_o}, 32'd0);
        check("midrun_rst_cyc", cycles_o, 32'd0);
        check("midrun_rst_err", 32'(err_code_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Random programs against the stream model
        for (int t = 0; t < 25; t++) begin
            gen_stream();
            run_stream($urandom_range(1, 60));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
